// File: rtl/uart_case_fifo.sv
// Case-converting FWFT FIFO between the UART receiver and transmitter.
// Optional drop counter port o_drop_cnt enabled by `define UART_CASE_FIFO_DROP_CNT_EN.
module uart_case_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [7:0]        i_wr_data,
  input  logic              i_wr_valid,
  input  logic [1:0]        i_mode,
  input  logic              i_tx_ready,
  input  logic              i_baud_tick,
  output logic [7:0]        o_tx_data,
  output logic              o_tx_valid,
  output logic [ADDR_W:0]   o_count,
  output logic              o_full,
  output logic              o_overflow
`ifdef UART_CASE_FIFO_DROP_CNT_EN
  ,
  output logic [7:0]        o_drop_cnt
`endif
);

  localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [7:0]      mem [DEPTH];
  logic [ADDR_W:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0] wr_ptr_nxt, rd_ptr_nxt;
  logic            push, pop, drop;
  logic [7:0]      conv_data;

  function automatic logic [7:0] case_conv(input logic [7:0] b, input logic [1:0] m);
    logic is_upper, is_lower;
    is_upper  = (b >= 8'h41) && (b <= 8'h5A);
    is_lower  = (b >= 8'h61) && (b <= 8'h7A);
    case_conv = b;
    case (m)
      2'd1:    if (is_lower) case_conv = b ^ 8'h20;
      2'd2:    if (is_upper) case_conv = b ^ 8'h20;
      2'd3:    if (is_upper || is_lower) case_conv = b ^ 8'h20;
      default: case_conv = b;
    endcase
  endfunction

  assign conv_data = case_conv(i_wr_data, i_mode);

  // A pop in the same cycle frees the slot, so a full FIFO still accepts the write.
  assign pop  = o_tx_valid && i_tx_ready && i_baud_tick;
  assign push = i_wr_valid && (!o_full || pop);
  assign drop = i_wr_valid && o_full && !pop;

  always_comb begin
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    if (push) wr_ptr_nxt = wr_ptr + PTR_ONE;
    if (pop)  rd_ptr_nxt = rd_ptr + PTR_ONE;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      o_tx_valid <= 1'b0;
      o_count    <= '0;
      o_full     <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      wr_ptr     <= wr_ptr_nxt;
      rd_ptr     <= rd_ptr_nxt;
      o_tx_valid <= (wr_ptr_nxt != rd_ptr_nxt);
      o_count    <= wr_ptr_nxt - rd_ptr_nxt;
      o_full     <= (wr_ptr_nxt[ADDR_W] != rd_ptr_nxt[ADDR_W]) &&
                    (wr_ptr_nxt[ADDR_W-1:0] == rd_ptr_nxt[ADDR_W-1:0]);
      if (drop) o_overflow <= 1'b1;
    end
  end

  // Storage is not reset; occupancy is tracked purely by the pointers.
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr[ADDR_W-1:0]] <= conv_data;
  end

  assign o_tx_data = mem[rd_ptr[ADDR_W-1:0]];

`ifdef UART_CASE_FIFO_DROP_CNT_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                       o_drop_cnt <= 8'h00;
    else if (drop && o_drop_cnt != 8'hFF) o_drop_cnt <= o_drop_cnt + 8'h01;
  end
`endif

endmodule

// File: tb/tb_uart_case_fifo.sv
// Self-checking bench for uart_case_fifo: vector table, corner sequences, random vs queue model.
module tb_uart_case_fifo;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic             i_clk = 1'b0;
  logic             i_rst;
  logic [7:0]       i_wr_data;
  logic             i_wr_valid;
  logic [1:0]       i_mode;
  logic             i_tx_ready;
  logic             i_baud_tick;
  logic [7:0]       o_tx_data;
  logic             o_tx_valid;
  logic [ADDR_W:0]  o_count;
  logic             o_full;
  logic             o_overflow;
`ifdef UART_CASE_FIFO_DROP_CNT_EN
  logic [7:0]       o_drop_cnt;
`endif

  uart_case_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_wr_data   (i_wr_data),
    .i_wr_valid  (i_wr_valid),
    .i_mode      (i_mode),
    .i_tx_ready  (i_tx_ready),
    .i_baud_tick (i_baud_tick),
    .o_tx_data   (o_tx_data),
    .o_tx_valid  (o_tx_valid),
    .o_count     (o_count),
    .o_full      (o_full),
    .o_overflow  (o_overflow)
`ifdef UART_CASE_FIFO_DROP_CNT_EN
    ,
    .o_drop_cnt  (o_drop_cnt)
`endif
  );

  always #5 i_clk = ~i_clk;

  int tests = 0;
  int fails = 0;

  // Reference model: a plain queue of converted bytes.
  byte unsigned m_q[$];
  bit           m_ovf;
  int           m_drop;

  function automatic byte unsigned ref_conv(input byte unsigned b, input int m);
    bit up = (b >= "A" && b <= "Z");
    bit lo = (b >= "a" && b <= "z");
    if (m == 1 && lo) return b - 32;
    if (m == 2 && up) return b + 32;
    if (m == 3 && lo) return b - 32;
    if (m == 3 && up) return b + 32;
    return b;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_ovf  = 0;
    m_drop = 0;
  endtask

  // Drive one cycle of inputs, advance the model at the edge, land 1ns after it.
  task automatic apply(input bit wv, input byte unsigned d, input int m, input bit rdy, input bit tk);
    bit do_pop;
    i_wr_valid  = wv;
    i_wr_data   = d;
    i_mode      = 2'(m);
    i_tx_ready  = rdy;
    i_baud_tick = tk;
    @(posedge i_clk);
    do_pop = (m_q.size() > 0) && rdy && tk;
    if (wv && (m_q.size() < DEPTH || do_pop)) begin
      if (do_pop) void'(m_q.pop_front());
      m_q.push_back(ref_conv(d, m));
    end else begin
      if (do_pop) void'(m_q.pop_front());
      if (wv) begin
        m_ovf = 1;
        if (m_drop < 255) m_drop++;
      end
    end
    #1;
    i_wr_valid  = 1'b0;
    i_tx_ready  = 1'b0;
    i_baud_tick = 1'b0;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_valid"}, 32'(o_tx_valid), 32'(m_q.size() != 0));
    chk({tag, "_count"}, 32'(o_count), 32'(m_q.size()));
    chk({tag, "_full"},  32'(o_full), 32'(m_q.size() == DEPTH));
    chk({tag, "_ovf"},   32'(o_overflow), 32'(m_ovf));
    if (m_q.size() != 0) chk({tag, "_data"}, 32'(o_tx_data), 32'(m_q[0]));
`ifdef UART_CASE_FIFO_DROP_CNT_EN
    chk({tag, "_dropcnt"}, 32'(o_drop_cnt), 32'(m_drop));
`endif
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    @(posedge i_clk);
    #4;
    i_rst = 1'b0;
    model_reset();
    #1;
  endtask

  typedef struct {
    bit          wv;
    logic [7:0]  d;
    int          m;
    bit          rdy;
    bit          tk;
    bit          e_valid;
    int          e_count;
    logic [7:0]  e_data;
  } vec_t;

  vec_t vecs[$];

  initial begin
    i_rst = 1'b1;
    i_wr_valid = 0; i_wr_data = 0; i_mode = 0; i_tx_ready = 0; i_baud_tick = 0;
    model_reset();
    #1;
    chk("reset_valid", 32'(o_tx_valid), 0);
    chk("reset_count", 32'(o_count), 0);
    chk("reset_full",  32'(o_full), 0);
    chk("reset_ovf",   32'(o_overflow), 0);
    do_reset();

    //        wv  data   m rdy tk  valid cnt data
    vecs = '{
      '{1, 8'h61, 1, 0, 0, 1, 1, 8'h41},
      '{1, 8'h5A, 1, 0, 0, 1, 2, 8'h41},
      '{1, 8'h31, 1, 0, 0, 1, 3, 8'h41},
      '{0, 8'h00, 1, 1, 1, 1, 2, 8'h5A},
      '{0, 8'h00, 1, 1, 0, 1, 2, 8'h5A},
      '{0, 8'h00, 1, 1, 1, 1, 1, 8'h31},
      '{0, 8'h00, 1, 1, 1, 0, 0, 8'h00},
      '{0, 8'h00, 1, 1, 1, 0, 0, 8'h00},
      '{1, 8'h48, 3, 0, 0, 1, 1, 8'h68},
      '{1, 8'h69, 0, 0, 0, 1, 2, 8'h68},
      '{0, 8'h00, 0, 1, 1, 1, 1, 8'h69},
      '{0, 8'h00, 0, 1, 1, 0, 0, 8'h00},
      '{1, 8'h7A, 2, 1, 1, 1, 1, 8'h7A},
      '{1, 8'h41, 2, 1, 1, 1, 1, 8'h61},
      '{1, 8'h5B, 3, 0, 1, 1, 2, 8'h61},
      '{0, 8'h00, 3, 1, 1, 1, 1, 8'h5B},
      '{0, 8'h00, 3, 1, 1, 0, 0, 8'h00}
    };
    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].wv, vecs[i].d, vecs[i].m, vecs[i].rdy, vecs[i].tk);
      chk($sformatf("vec%0d_valid", i), 32'(o_tx_valid), 32'(vecs[i].e_valid));
      chk($sformatf("vec%0d_count", i), 32'(o_count), 32'(vecs[i].e_count));
      if (vecs[i].e_valid) chk($sformatf("vec%0d_data", i), 32'(o_tx_data), 32'(vecs[i].e_data));
    end

    // Overflow: 17 writes with the transmitter busy.
    do_reset();
    for (int i = 0; i < 17; i++) apply(1, 8'(8'h80 + i), 0, 0, 0);
    chk("ovf_full",  32'(o_full), 1);
    chk("ovf_count", 32'(o_count), 16);
    chk("ovf_flag",  32'(o_overflow), 1);
`ifdef UART_CASE_FIFO_DROP_CNT_EN
    chk("ovf_dropcnt", 32'(o_drop_cnt), 1);
`endif
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("ovf_drain%0d", i), 32'(o_tx_data), 32'(8'h80 + i));
      apply(0, 0, 0, 1, 1);
    end
    chk("ovf_empty_valid", 32'(o_tx_valid), 0);
    chk("ovf_sticky", 32'(o_overflow), 1);

    // Async reset mid-stream clears state without a clock edge.
    for (int i = 0; i < 3; i++) apply(1, 8'(8'h30 + i), 0, 0, 0);
    #2 i_rst = 1'b1;
    #1;
    chk("arst_valid", 32'(o_tx_valid), 0);
    chk("arst_count", 32'(o_count), 0);
    chk("arst_ovf",   32'(o_overflow), 0);
    #1 i_rst = 1'b0;
    model_reset();
    apply(1, 8'h7A, 2, 0, 0);
    chk("arst_after_valid", 32'(o_tx_valid), 1);
    chk("arst_after_data",  32'(o_tx_data), 32'h7A);
    apply(0, 0, 0, 1, 1);

    // Full FIFO with simultaneous push and pop.
    do_reset();
    for (int i = 0; i < 16; i++) apply(1, 8'(8'h90 + i), 0, 0, 0);
    chk("fpp_pre_full", 32'(o_full), 1);
    apply(1, 8'hAA, 0, 1, 1);
    chk("fpp_count", 32'(o_count), 16);
    chk("fpp_full",  32'(o_full), 1);
    chk("fpp_ovf",   32'(o_overflow), 0);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("fpp_drain%0d", i), 32'(o_tx_data), (i < 15) ? 32'(8'h91 + i) : 32'hAA);
      apply(0, 0, 0, 1, 1);
    end
    chk("fpp_empty", 32'(o_tx_valid), 0);

    // Pop gating on baud tick.
    do_reset();
    apply(1, 8'h11, 0, 0, 0);
    apply(1, 8'h22, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      apply(0, 0, 0, 1, 0);
      chk($sformatf("gate_hold%0d", i), 32'(o_tx_data), 32'h11);
    end
    apply(0, 0, 0, 1, 1);
    chk("gate_adv_data",  32'(o_tx_data), 32'h22);
    chk("gate_adv_count", 32'(o_count), 1);

    // Randomized traffic against the queue model, with varying drain rates.
    do_reset();
    for (int blk = 0; blk < 12; blk++) begin
      int rdy_pct = (blk % 3 == 0) ? 10 : ((blk % 3 == 1) ? 90 : 50);
      for (int c = 0; c < 250; c++) begin
        byte unsigned d;
        d = 8'($urandom_range(0, 255));
        if ($urandom_range(0, 1) == 1) d = 8'($urandom_range(8'h40, 8'h7B));
        apply($urandom_range(0, 99) < 60, d, $urandom_range(0, 3),
              $urandom_range(0, 99) < rdy_pct, $urandom_range(0, 1) == 1);
        check_model("rnd");
      end
      if (blk == 5) do_reset();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uart_case_fifo.md
Name: uart_case_fifo

Overview:
- Sits between the UART receiver and the UART transmitter in the case-converter datapath.
- Accepts one received byte per write strobe and applies the selected ASCII case conversion at write time.
- Buffers converted bytes in a first-word-fall-through FIFO.
- Presents bytes to the transmitter with the same valid/ready/baud_tick acceptance rule the transmitter itself applies, so each byte is popped exactly once.

Parameters:
- DEPTH, 16, FIFO entries; power of two, minimum 2.
- ADDR_W, 4, log2(DEPTH); must be consistent with DEPTH.

Ports:
- i_clk  input  1  system clock
- i_rst  input  1  reset, asynchronous, active-high
- i_wr_data  input  8  byte from receiver
- i_wr_valid  input  1  single-cycle write strobe from receiver; no backpressure
- i_mode  input  2  conversion: 0 pass, 1 upper, 2 lower, 3 toggle case
- i_tx_ready  input  1  transmitter idle (its o_ready)
- i_baud_tick  input  1  baud tick shared with transmitter
- o_tx_data  output  8  head-of-FIFO byte
- o_tx_valid  output  1  FIFO not empty
- o_count  output  ADDR_W+1  current occupancy, 0..DEPTH
- o_full  output  1  occupancy == DEPTH
- o_overflow  output  1  sticky; set when a write is dropped

Behaviour:
- Reset (async, i_rst=1): pointers=0, o_count=0, o_tx_valid=0, o_full=0, o_overflow=0, o_tx_data undefined; buffered contents are discarded immediately, including mid-stream.
- Conversion (combinational on i_wr_data, using i_mode in the write cycle):
  - upper: 0x61..0x7A minus 0x20.
  - lower: 0x41..0x5A plus 0x20.
  - toggle: letters in either range XOR 0x20.
  - All other bytes pass unchanged; pass mode never modifies.
- Push: i_wr_valid=1 and not full -> converted byte written at wr_ptr; wr_ptr+1.
- Pop: o_tx_valid && i_tx_ready && i_baud_tick, all in the same cycle -> rd_ptr+1. This is the exact cycle the transmitter latches the byte.
- Pointers: ADDR_W+1 bits with natural wrap. Empty when the pointers are equal; full when the MSBs differ and the lower bits are equal.
- FWFT timing: o_tx_data = mem[rd_ptr[ADDR_W-1:0]]. o_tx_valid = !empty, registered from the pointers, so a push into an empty FIFO is visible the next cycle. There is no same-cycle bypass.
- Outputs o_count, o_full, o_tx_valid update the cycle after the push/pop edge.
- Simultaneous push+pop, not empty, not full: both occur; count unchanged.
- Simultaneous push+pop when full: the pop frees a slot, the push is accepted, no overflow; count stays DEPTH.
- Push while empty with pop conditions true: no pop (o_tx_valid=0); the push is accepted.
- Push when full without a pop: byte dropped, o_overflow set to 1 and held until reset.
- i_mode changes affect only later writes; stored bytes are never reconverted.
- Pop conditions without o_tx_valid: no effect; rd_ptr holds.
- Throughput: one push per cycle; pop rate bounded by the transmitter (at most one byte per 10 baud ticks).

Optional Feature:
- Macro UART_CASE_FIFO_DROP_CNT_EN.
- Defined: adds output port o_drop_cnt (8 bits), reset 0. It increments on each dropped write and saturates at 0xFF. o_overflow behaviour is unchanged.
- Undefined: the port and counter are absent; only the sticky o_overflow reports drops.

Test Plan:
- Mode 1, write 0x61 ('a'), 0x5A ('Z'), 0x31 ('1') -> o_tx_data sequence 0x41, 0x5A, 0x31 popped in order; o_count returns to 0; o_tx_valid=0.
- Mode 3, write 0x48 0x69 ('Hi'); mode switched to 0 after the first write -> output 0x68, 0x69 (second write passes unchanged).
- Hold i_tx_ready=0, write 17 bytes with DEPTH=16 -> o_full=1, o_count=16, o_overflow=1, 17th byte absent. With the macro defined, o_drop_cnt=1.
- Full FIFO, push and pop (ready=1, tick=1) in the same cycle -> o_count stays 16, o_overflow stays 0, the new byte appears after the 15 older ones.
- Pop gating: valid=1, ready=1, tick=0 for 5 cycles -> head unchanged. Then tick=1 for one cycle -> head advances by exactly one entry.
- Write 3 bytes, assert i_rst for one cycle between clock edges -> o_tx_valid, o_count, o_overflow go to 0 immediately. A subsequent write of 0x7A in mode 2 -> o_tx_data=0x7A.
